// File: rtl/axis_threshold_sequencer.sv
// axis_threshold_sequencer
//   Sequences the comparator threshold word on an AXI-Stream master port:
//   idle level -> active level for cfg_hold cycles on a trig_in rising edge ->
//   idle level plus a cfg_holdoff dead time, then back to idle.
//   Optional: define AXIS_THRESHOLD_SEQ_RETRIG_EN so that a trigger arriving
//   while ACTIVE restarts the hold count.
module axis_threshold_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_level_idle,
  input  logic [AXIS_TDATA_WIDTH-1:0] cfg_level_active,
  input  logic [CNTR_WIDTH-1:0]       cfg_hold,
  input  logic [CNTR_WIDTH-1:0]       cfg_holdoff,
  input  logic                        trig_in,
  output logic                        state_data,
  output logic                        busy,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

  logic [1:0]                  state, state_nxt;
  logic [CNTR_WIDTH-1:0]       cnt, cnt_nxt;
  logic                        trig_q;
  logic                        trig_rise;
  logic                        pub_idle;
  logic                        sd_nxt;
  logic                        data_chg;
  logic [AXIS_TDATA_WIDTH-1:0] data_nxt;
  logic [CNTR_WIDTH-1:0]       hold_load;

  assign trig_rise = trig_in & ~trig_q;
  assign busy      = (state != ST_IDLE);
  // A zero hold still yields one ACTIVE cycle.
  assign hold_load = (cfg_hold == '0) ? '0 : cfg_hold - CNT_ONE;

  // Next-state, counter and threshold-word selection
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sd_nxt    = state_data;
    data_chg  = 1'b0;
    data_nxt  = m_axis_tdata;
    // Post-reset idle publish; a same-cycle trigger below overrides it.
    if (pub_idle) begin
      data_chg = 1'b1;
      data_nxt = cfg_level_idle;
    end
    case (state)
      ST_IDLE: begin
        if (trig_rise) begin
          state_nxt = ST_ACTIVE;
          cnt_nxt   = hold_load;
          sd_nxt    = 1'b1;
          data_chg  = 1'b1;
          data_nxt  = cfg_level_active;
        end
      end
      ST_ACTIVE: begin
        // Exit takes priority over a coincident trigger.
        if (cnt == '0) begin
          sd_nxt   = 1'b0;
          data_chg = 1'b1;
          data_nxt = cfg_level_idle;
          if (cfg_holdoff != '0) begin
            state_nxt = ST_HOLDOFF;
            cnt_nxt   = cfg_holdoff - CNT_ONE;
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
`ifdef AXIS_THRESHOLD_SEQ_RETRIG_EN
        else if (trig_rise) begin
          cnt_nxt = hold_load;
        end
`endif
        else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_HOLDOFF: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        sd_nxt    = 1'b0;
      end
    endcase
  end

  // State, counter, edge detect and stream registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      trig_q        <= 1'b0;
      pub_idle      <= 1'b1;
      state_data    <= 1'b0;
      m_axis_tdata  <= '1;
      m_axis_tvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      trig_q     <= trig_in;
      pub_idle   <= 1'b0;
      state_data <= sd_nxt;
      if (data_chg) begin
        m_axis_tdata  <= data_nxt;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
